seq4_sched: RTL and testbench
=============================

# seq4_sched

Scheduler that shares one 4-bit sequence counter between two requesters. Each requester asks for a run and supplies a start value, an end value and a direction. The block arbitrates round-robin, loads the counter, steps it once per clock until the end value is reached, then signals completion to the granted requester. It sits in front of the 4-bit `x` sequence datapath and is the only driver of `x`.

## Interface
- WIDTH, 4, counter and config width; all arithmetic is modulo 2^WIDTH.
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  request, level-sensitive, one bit per requester. Held high until that requester's `done` bit is seen.
- cfg0_start, cfg1_start  in  WIDTH  first counter value for requester 0/1.
- cfg0_end, cfg1_end  in  WIDTH  last counter value for requester 0/1.
- cfg0_dir, cfg1_dir  in  1  1 = count up, 0 = count down.
- pause  in  1  holds the counter while in RUN. Ignored in other states.
- x  out  WIDTH  counter value, registered.
- grant  out  2  one-hot owner of the current run; 00 when idle.
- busy  out  1  high in RUN and DONE.
- done  out  2  one-cycle pulse on the owner's bit when its run completes.

## Operation
- States:
  - IDLE: grant = 00, busy = 0, x holds its last value.
  - RUN: owner's configuration is latched; x steps.
  - DONE: one cycle; done pulses; x holds.
- Arbitration: in IDLE, one or more `req` bits high selects the winner. A pointer `prio` picks the preferred requester.
  - If only one requester is asking, it wins.
  - If both are asking, `prio` wins.
  - After every grant, `prio` moves to the other requester.
  - Reset value of `prio` = requester 0.
- Grant edge: transition IDLE→RUN. On this edge:
  - `grant` is set one-hot.
  - `x` <= owner's `cfg_start`.
  - Owner's `cfg_end` and `cfg_dir` are copied into internal registers.
  - Config inputs are not sampled again until the next grant.
- RUN, on each edge:
  - `pause` = 1: `x` holds; stay in RUN.
  - Else, if `x` == latched end: go to DONE; `x` holds.
  - Else: `x` <= x+1 (dir = 1) or x−1 (dir = 0), modulo 16. This wraps 15→0 up and 0→15 down.
- DONE:
  - `done[owner]` = 1 and `grant` still shows the owner.
  - Next edge goes to IDLE with `grant` = 00.
- Requester protocol:
  - The requester must drop `req` in the cycle `done` is seen.
  - If `req` is still high in IDLE, it is treated as a new request and arbitrated normally.
- `req` dropped during RUN: the run still completes. Runs are not aborted except by reset.
- Reset, asserted at any time, immediately forces:
  - state IDLE; x = 0, grant = 00, busy = 0, done = 00; `prio` = requester 0.
  - No `done` pulse is produced for an interrupted run.

## Timing
- Request to grant: `req` seen high in IDLE at edge k gives `grant`, `busy` and `x` = start valid after edge k.
- Run length with no pause: N edges in RUN, where N = ((end − start) mod 16) + 1 for up, and ((start − end) mod 16) + 1 for down. The end value is visible for one cycle before DONE.
- start == end: x = start for one cycle in RUN, then DONE.
- Pause: each paused cycle adds exactly one cycle to the run.
- DONE to next grant: DONE lasts 1 cycle and IDLE lasts at least 1 cycle. Minimum 2 cycles from the `done` pulse to the next grant.
- All outputs are registered. No combinational path from inputs to outputs.
- Asynchronous reset: asserting `reset_n` low clears outputs without a clock edge. Deassertion is synchronous to the bench; the first edge with `reset_n` = 1 may grant.

## Test plan
- Reset, then a single up run: reset low 60 ns, then req = 01, cfg0 = (start 3, end 7, dir 1) → grant = 01 after the next edge; x = 3,4,5,6,7 on consecutive cycles; done = 01 for one cycle; grant = 00 afterwards. Clock period 50 ns.
- Wrap on a down run: cfg1 = (start 1, end 14, dir 0), req = 10 → x = 1,0,15,14, then done = 10.
- Contention: req = 11 held, each requester dropping its bit on its `done`:
  - first grant = 01 (prio reset value); grant = 10 follows after DONE+IDLE.
  - Repeat with both requests re-raised → the next grant alternates back to 01.
- Pause: during a 0→4 up run, hold pause = 1 for 3 cycles at x = 2 → x stays 2 for 4 cycles total; the run ends 3 cycles later than without pause; done is still a single pulse.
- Degenerate run and config change: start = end = 9 → x = 9 for one RUN cycle, then done. Changing cfg0 inputs mid-run must not alter the latched end or dir.
- Reset mid-run: assert reset_n = 0 while x = 5 in RUN → x = 0, grant = 00, busy = 0 immediately without a clock edge; no done pulse.
- Reset mid-run, re-arbitration: after releasing reset with req = 11 → requester 0 is granted first.

Source files
------------

// File: rtl/seq4_sched.sv
// Round-robin scheduler that shares one WIDTH-bit sequence counter between two requesters.
// States: IDLE (arbitrate) | RUN (x steps toward the latched end) | DONE (one-cycle completion pulse).
module seq4_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] cfg0_start,
  input  logic [WIDTH-1:0] cfg0_end,
  input  logic             cfg0_dir,
  input  logic [WIDTH-1:0] cfg1_start,
  input  logic [WIDTH-1:0] cfg1_end,
  input  logic             cfg1_dir,
  input  logic             pause,
  output logic [WIDTH-1:0] x,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic             dir_q, dir_d;
  logic [1:0]       grant_q, grant_d;
  logic             prio_q, prio_d;
  logic             busy_q, busy_d;
  logic [1:0]       done_q, done_d;
  logic             winner;

  // Sole asker wins; on contention the priority pointer decides.
  always_comb begin
    winner = prio_q;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    end_d   = end_q;
    dir_d   = dir_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 2'b00;
        if (req != 2'b00) begin
          state_d = S_RUN;
          prio_d  = ~winner;
          grant_d = winner ? 2'b10 : 2'b01;
          x_d     = winner ? cfg1_start : cfg0_start;
          end_d   = winner ? cfg1_end   : cfg0_end;
          dir_d   = winner ? cfg1_dir   : cfg0_dir;
        end
      end
      S_RUN: begin
        if (!pause) begin
          if (x_q == end_q) state_d = S_DONE;
          else if (dir_q)   x_d = x_q + WIDTH'(1);
          else              x_d = x_q - WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) ? grant_d : 2'b00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      end_q   <= '0;
      dir_q   <= 1'b0;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      end_q   <= end_d;
      dir_q   <= dir_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq4_sched.sv
// Directed and randomized checks of seq4_sched against a sequence-level reference model.
module tb_seq4_sched;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [3:0] cfg0_start, cfg0_end, cfg1_start, cfg1_end;
  logic       cfg0_dir, cfg1_dir;
  logic       pause;
  logic [3:0] x;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] done;

  int n_chk  = 0;
  int n_fail = 0;
  bit prio_m = 1'b0;

  seq4_sched #(.WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .cfg0_start(cfg0_start), .cfg0_end(cfg0_end), .cfg0_dir(cfg0_dir),
    .cfg1_start(cfg1_start), .cfg1_end(cfg1_end), .cfg1_dir(cfg1_dir),
    .pause(pause), .x(x), .grant(grant), .busy(busy), .done(done)
  );

  always #25 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] ex, input logic [1:0] eg,
                               input logic eb, input logic [1:0] ed);
    chk({tag, "_x"},     8'(x),     8'(ex));
    chk({tag, "_grant"}, 8'(grant), 8'(eg));
    chk({tag, "_busy"},  8'(busy),  8'(eb));
    chk({tag, "_done"},  8'(done),  8'(ed));
  endtask

  // One complete run: expected x sequence is start +/- k for k < N, each value
  // repeated once per paused edge; pk/pn force pn pause edges on the k-th value.
  task automatic run_one(input logic [1:0] rq,
                         input logic [3:0] s0, input logic [3:0] e0, input logic d0,
                         input logic [3:0] s1, input logic [3:0] e1, input logic d1,
                         input int pk, input int pn, input int maxp, input bit chg);
    logic       owner;
    logic [1:0] oh;
    logic [3:0] s, e, v;
    logic       d;
    int         n, p;
    req = rq;
    cfg0_start = s0; cfg0_end = e0; cfg0_dir = d0;
    cfg1_start = s1; cfg1_end = e1; cfg1_dir = d1;
    pause = 1'($urandom_range(0, 1));
    owner = (rq == 2'b11) ? prio_m : rq[1];
    oh    = owner ? 2'b10 : 2'b01;
    s     = owner ? s1 : s0;
    e     = owner ? e1 : e0;
    d     = owner ? d1 : d0;
    prio_m = ~owner;
    n = d ? (((int'(e) - int'(s)) & 15) + 1) : (((int'(s) - int'(e)) & 15) + 1);
    for (int k = 0; k < n; k++) begin
      v = d ? (s + 4'(k)) : (s - 4'(k));
      p = (k == pk) ? pn : ((maxp > 0) ? int'($urandom_range(0, maxp)) : 0);
      for (int j = 0; j <= p; j++) begin
        @(posedge clock); #1;
        check_outputs("run", v, oh, 1'b1, 2'b00);
        pause = (j < p);
        if (chg && k == 0 && j == 0) begin
          cfg0_start = 4'($urandom); cfg0_end = 4'($urandom); cfg0_dir = 1'($urandom);
          cfg1_start = 4'($urandom); cfg1_end = 4'($urandom); cfg1_dir = 1'($urandom);
        end
      end
    end
    @(posedge clock); #1;
    check_outputs("done", e, oh, 1'b1, oh);
    req   = req & ~oh;
    pause = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    check_outputs("idle", e, 2'b00, 1'b0, 2'b00);
    pause = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req = 2'b00; pause = 1'b0;
    cfg0_start = 4'd0; cfg0_end = 4'd0; cfg0_dir = 1'b0;
    cfg1_start = 4'd0; cfg1_end = 4'd0; cfg1_dir = 1'b0;
    #10;
    check_outputs("reset", 4'd0, 2'b00, 1'b0, 2'b00);
    #50 reset_n = 1'b1;

    run_one(2'b01, 4'd3, 4'd7, 1'b1, 4'd0, 4'd0, 1'b0, -1, 0, 0, 1'b0);
    run_one(2'b10, 4'd0, 4'd0, 1'b0, 4'd1, 4'd14, 1'b0, -1, 0, 0, 1'b0);

    // Contention: prio was left at 0 after granting requester 1.
    run_one(2'b11, 4'd2, 4'd4, 1'b1, 4'd9, 4'd7, 1'b0, -1, 0, 0, 1'b0);
    run_one(2'b10, 4'd2, 4'd4, 1'b1, 4'd9, 4'd7, 1'b0, -1, 0, 0, 1'b0);
    run_one(2'b11, 4'd15, 4'd1, 1'b1, 4'd5, 4'd6, 1'b1, -1, 0, 0, 1'b0);
    run_one(2'b10, 4'd15, 4'd1, 1'b1, 4'd5, 4'd6, 1'b1, -1, 0, 0, 1'b0);

    run_one(2'b01, 4'd0, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 2, 3, 0, 1'b0);
    run_one(2'b01, 4'd9, 4'd9, 1'b1, 4'd0, 4'd0, 1'b0, -1, 0, 0, 1'b1);
    run_one(2'b01, 4'd12, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, -1, 0, 0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      run_one(rq, 4'($urandom), 4'($urandom), 1'($urandom),
              4'($urandom), 4'($urandom), 1'($urandom), -1, 0, 2, 1'($urandom));
    end

    // Reset in the middle of a run; requester 0 wins so prio would point at 1.
    req = 2'b01; cfg0_start = 4'd2; cfg0_end = 4'd10; cfg0_dir = 1'b1;
    prio_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
    end
    check_outputs("pre_rst", 4'd5, 2'b01, 1'b1, 2'b00);
    #5 reset_n = 1'b0;
    #1 check_outputs("async_rst", 4'd0, 2'b00, 1'b0, 2'b00);
    prio_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check_outputs("in_rst", 4'd0, 2'b00, 1'b0, 2'b00);
    end
    reset_n = 1'b1;
    run_one(2'b11, 4'd6, 4'd8, 1'b1, 4'd1, 4'd0, 1'b0, -1, 0, 0, 1'b0);
    run_one(2'b10, 4'd6, 4'd8, 1'b1, 4'd1, 4'd0, 1'b0, -1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
